// File: rtl/uart_rx_frame_if.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_if
// Character output bundle of the UART receive front end.
//   re       : one-cycle strobe, a character is valid on rx_data/rx_error
//   rx_data  : received character, held until the next re
//   rx_error : framing / flagged-parity error for the character, valid with re
//   rx_busy  : a frame is in progress
// master modport: the receiver that drives the bundle.
// slave modport : the consumer (RX ring buffer) that observes it.
// -----------------------------------------------------------------------------
interface uart_rx_frame_if;
    logic       re;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       rx_busy;

    modport master (
        output re,
        output rx_data,
        output rx_error,
        output rx_busy
    );

    modport slave (
        input re,
        input rx_data,
        input rx_error,
        input rx_busy
    );
endinterface

// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
// Serial receive front end: synchronises the asynchronous rx line, frames
// 8-bit characters (LSB first) with optional parity and one stop bit, and
// emits one-cycle re strobes carrying rx_data/rx_error.
// Ports:
//   ifclk             : system clock, rising edge
//   resetb            : asynchronous active-low reset
//   clk_div           : ifclk cycles per bit (values below 4 act as 4)
//   parity_mode       : 0/3 none, 1 odd, 2 even
//   parity_error_mode : 0/3 ignore, 1 drop byte, 2 flag byte
//   rx                : asynchronous serial line, idle high
//   rxo               : character output bundle (re, rx_data, rx_error, rx_busy)
// -----------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int CLK_DIV_WIDTH = 16
) (
    input  logic                     ifclk,
    input  logic                     resetb,
    input  logic [CLK_DIV_WIDTH-1:0] clk_div,
    input  logic [1:0]               parity_mode,
    input  logic [1:0]               parity_error_mode,
    input  logic                     rx,
    uart_rx_frame_if.master          rxo
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity error for a character: odd mode wants XOR(data,p)==1,
    // even mode wants XOR(data,p)==0; other modes never report an error.
    function automatic logic parity_err_f(input logic [7:0] data,
                                          input logic       p,
                                          input logic [1:0] mode);
        logic x;
        x = (^data) ^ p;
        case (mode)
            2'd1:    parity_err_f = (x == 1'b0);
            2'd2:    parity_err_f = (x == 1'b1);
            default: parity_err_f = 1'b0;
        endcase
    endfunction

    state_t                   state_q, state_d;
    logic                     sync1_q;
    logic                     rx_s_q;
    logic                     rx_s_d_q;
    logic [CLK_DIV_WIDTH-1:0] tick_q, tick_d;
    logic [CLK_DIV_WIDTH-1:0] div_q, div_d;
    logic [1:0]               pm_q, pm_d;
    logic [1:0]               pem_q, pem_d;
    logic [2:0]               bit_q, bit_d;
    logic [7:0]               shift_q, shift_d;
    logic                     perr_q, perr_d;
    logic                     re_q, re_d;
    logic [7:0]               data_q, data_d;
    logic                     err_q, err_d;
    logic                     busy_q, busy_d;

    logic                     start_det;
    logic                     tick_zero;
    logic                     par_en;
    logic                     framing_err;
    logic                     char_err;
    logic                     char_drop;
    logic [CLK_DIV_WIDTH-1:0] div_clamped;

    // Edge detect on the synchronised line; only meaningful in IDLE.
    assign start_det   = (state_q == ST_IDLE) && rx_s_d_q && !rx_s_q;
    assign tick_zero   = (tick_q == {CLK_DIV_WIDTH{1'b0}});
    assign par_en      = (pm_q == 2'd1) || (pm_q == 2'd2);
    assign div_clamped = (clk_div < CLK_DIV_WIDTH'(4)) ? CLK_DIV_WIDTH'(4) : clk_div;
    // Stop-bit result; only consumed on the stop sample.
    assign framing_err = !rx_s_q;
    assign char_err    = framing_err || (perr_q && (pem_q == 2'd2));
    assign char_drop   = perr_q && (pem_q == 2'd1) && !framing_err;

    // Two-flop synchroniser plus one delayed copy for falling-edge detect.
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            sync1_q  <= 1'b1;
            rx_s_q   <= 1'b1;
            rx_s_d_q <= 1'b1;
        end else begin
            sync1_q  <= rx;
            rx_s_q   <= sync1_q;
            rx_s_d_q <= rx_s_q;
        end
    end

    // Frame state, counters, latched configuration and registered outputs.
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
            tick_q  <= {CLK_DIV_WIDTH{1'b0}};
            div_q   <= CLK_DIV_WIDTH'(4);
            pm_q    <= 2'd0;
            pem_q   <= 2'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            perr_q  <= 1'b0;
            re_q    <= 1'b0;
            data_q  <= 8'h00;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            div_q   <= div_d;
            pm_q    <= pm_d;
            pem_q   <= pem_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            re_q    <= re_d;
            data_q  <= data_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and datapath: every sample happens when the tick counter
    // reaches zero in a non-idle state.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        div_d   = div_q;
        pm_d    = pm_q;
        pem_d   = pem_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        re_d    = 1'b0;
        data_d  = data_q;
        err_d   = err_q;

        if (state_q != ST_IDLE) begin
            if (tick_zero) begin
                tick_d = div_q - CLK_DIV_WIDTH'(1);
            end else begin
                tick_d = tick_q - CLK_DIV_WIDTH'(1);
            end
        end else begin
            tick_d = tick_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_det) begin
                    // First sample lands mid start bit: floor(div/2) cycles on.
                    div_d   = div_clamped;
                    pm_d    = parity_mode;
                    pem_d   = parity_error_mode;
                    tick_d  = (div_clamped >> 1) - CLK_DIV_WIDTH'(1);
                    bit_d   = 3'd0;
                    perr_d  = 1'b0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_zero) begin
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        bit_d   = 3'd0;
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_zero) begin
                    shift_d[bit_q] = rx_s_q;
                    if (bit_q == 3'd7) begin
                        state_d = par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_zero) begin
                    perr_d  = parity_err_f(shift_q, rx_s_q, pm_q);
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_zero) begin
                    state_d = ST_IDLE;
                    if (!char_drop) begin
                        re_d   = 1'b1;
                        data_d = shift_q;
                        err_d  = char_err;
                    end else begin
                        re_d = 1'b0;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Busy follows the next state so it drops together with the re strobe.
        busy_d = (state_d != ST_IDLE);
    end

    assign rxo.re       = re_q;
    assign rxo.rx_data  = data_q;
    assign rxo.rx_error = err_q;
    assign rxo.rx_busy  = busy_q;

endmodule
